// File: rtl/serial_byte_collector.sv
// serial_byte_collector: gathers WIDTH serial bits into a word and hands it off with valid/ack
//   clock_1MHz  : clock, rising edge
//   rst         : async reset, active low
//   data_in     : serial bit, taken when write_in=1 and status_out=1
//   write_in    : bit strobe
//   ack_in      : consumer takes the held word (HOLD only)
//   status_out  : ready for a bit (COLLECT)
//   data_out    : last completed word, first bit in MSB
//   data_ready  : data_out holds an unacknowledged word
//   overrun_out : sticky, a write hit HOLD without ack
//   bit_count   : bits gathered in the current word
module serial_byte_collector #(
  parameter int WIDTH = 8
) (
  input  logic                         clock_1MHz,
  input  logic                         rst,
  input  logic                         data_in,
  input  logic                         write_in,
  input  logic                         ack_in,
  output logic                         status_out,
  output logic [WIDTH-1:0]             data_out,
  output logic                         data_ready,
  output logic                         overrun_out,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count
);
  localparam int CW = $clog2(WIDTH+1);
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d, data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic over_q, over_d;
  logic accept, last;
  assign accept = state_q == COLLECT && write_in;
  assign last = cnt_q == CW'(WIDTH-1);
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    data_d = data_q;
    cnt_d = cnt_q;
    over_d = over_q;
    if (state_q == IDLE) state_d = COLLECT;
    if (accept) begin
      shift_d = {shift_q[WIDTH-2:0], data_in};
      cnt_d = last ? '0 : cnt_q + CW'(1);
      if (last) begin
        data_d = shift_d;
        state_d = HOLD;
      end
    end
    // ack wins over a simultaneous write: the write is dropped and the flag cleared
    if (state_q == HOLD) begin
      if (ack_in) begin
        over_d = 1'b0;
        state_d = COLLECT;
      end else if (write_in) over_d = 1'b1;
    end
  end
  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
      over_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
      over_q <= over_d;
    end
  end
  assign status_out = state_q == COLLECT;
  assign data_ready = state_q == HOLD;
  assign overrun_out = over_q;
  assign data_out = data_q;
  assign bit_count = cnt_q;
endmodule

// File: doc/serial_byte_collector.md
# serial_byte_collector

Upstream feed for the byte queue: collects `WIDTH` serial bits strobed by `write_in` into one parallel word, presents it on `data_out` with a valid/ack handshake toward the enqueue logic, and drives `status_out` high whenever it can take another bit. It owns the bit counter, the shift register and the "busy/ready" indication that the external bit source polls before each write.

## Interface

Parameters:

- `WIDTH`, default 8: bits per collected word; legal range 2–16.

Ports:

- `clock_1MHz` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `data_in` in 1: serial data bit; sampled only when `write_in`=1.
- `write_in` in 1: bit strobe; one bit is accepted per rising edge with `write_in`=1 and `status_out`=1.
- `ack_in` in 1: consumer accepts the presented word; effective only in HOLD.
- `status_out` out 1: 1 = ready to accept a bit (COLLECT state).
- `data_out` out WIDTH: last completed word, MSB = first bit received.
- `data_ready` out 1: 1 = `data_out` holds an unacknowledged word.
- `overrun_out` out 1: sticky flag; a write was attempted while in HOLD.
- `bit_count` out $clog2(WIDTH+1): number of bits collected in the current word.

## Operation

- FSM states: IDLE, COLLECT, HOLD.
- IDLE: entered on reset; unconditionally moves to COLLECT on the first rising edge after `rst` deasserts.
- COLLECT: `status_out`=1. On an edge with `write_in`=1, `shift <= {shift[WIDTH-2:0], data_in}` and `bit_count` increments. On the edge that accepts bit number WIDTH, `data_out <= {shift[WIDTH-2:0], data_in}`, `data_ready` goes to 1, `bit_count` goes to 0, and the state moves to HOLD.
- HOLD: `status_out`=0 and `write_in` is not shifted. If `write_in`=1 and `ack_in`=0 on an edge, `overrun_out` is set to 1. If `ack_in`=1, then on that edge `data_ready` goes to 0, `overrun_out` goes to 0, and the state moves to COLLECT. A `write_in` in the same cycle as `ack_in` is dropped and does not set `overrun_out`.
- `ack_in` in IDLE or COLLECT is ignored.
- `data_out` is not cleared on ack; it holds until the next word completes.
- `bit_count` saturates logic-wise at WIDTH-1 in COLLECT; it never shows WIDTH.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing

- Reset values (asynchronous, immediate while `rst`=0): state IDLE, `status_out`=0, `data_ready`=0, `overrun_out`=0, `data_out`=0, `shift`=0, `bit_count`=0.
- First edge after release: `status_out` goes to 1.
- Word latency: `data_ready` rises immediately after the edge that samples the last bit, i.e. zero extra cycles.
- `status_out` falls on that same edge, so the source sees it low before its next strobe.
- Ack turnaround: after the edge sampling `ack_in`=1, `status_out`=1 and `data_ready`=0. The next bit can be written on the following edge.
- Reset asserted mid-word or in HOLD discards the partial or held word and returns to IDLE asynchronously.
- A `write_in` held high for several cycles accepts one bit per cycle.

## Test plan

- Reset release: hold `rst`=0 for 2 cycles, then release. All outputs are 0 during reset; `status_out`=1 exactly one edge after release.
- Basic word: with WIDTH=8, write bits 1,0,1,1,0,0,1,0 with one idle cycle between strobes. Expect `data_out`=0xB2, `data_ready`=1 and `status_out`=0 right after the 8th strobe; `bit_count` steps 1..7 and then 0.
- Alternating source: bits i[0] for i=0..7, each written after waiting for `status_out`=1. Expect `data_out`=0x55.
- Overrun: after a completed word, pulse `write_in` with no ack. Expect `overrun_out`=1, `data_out` unchanged and `bit_count`=0. Then ack: `overrun_out`=0, `data_ready`=0, `status_out`=1.
- Simultaneous ack and write in HOLD: expect the write dropped, `overrun_out` to stay 0, and the next word to start from `bit_count`=0. Continuous `write_in` afterwards yields a word from 8 consecutive cycles.
- Mid-word reset: after 5 bits, assert `rst` for 1 cycle. Expect `bit_count`=0, `data_out`=0 and `data_ready`=0; a following full word of 0xFF is collected correctly.
